dma_timing_ctrl: RTL and testbench

// Transfer timing and control engine of the 8237A-style DMA controller; sits directly downstream of the

---
 rtl/dma_timing_ctrl_if.sv | 33 +++
 rtl/dma_timing_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_dma_timing_ctrl.sv | 365 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_timing_ctrl_if.sv
// DMA bus-side handshake and strobe bundle.
// master = timing engine, slave = CPU/bus side.
interface dma_timing_ctrl_if #(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 16
);
  logic              HRQ;
  logic              HLDA;
  logic              AEN;
  logic              ADSTB;
  logic [ADDR_W-1:0] addrOut;
  logic [NUM_CH-1:0] DACK;
  logic              MEMR_n;
  logic              MEMW_n;
  logic              IOR_n;
  logic              IOW_n;
  logic              EOP_in_n;
  logic              EOP_out_n;

  modport master (
    output HRQ, AEN, ADSTB, addrOut, DACK,
    output MEMR_n, MEMW_n, IOR_n, IOW_n,
    output EOP_out_n,
    input  HLDA, EOP_in_n
  );

  modport slave (
    input  HRQ, AEN, ADSTB, addrOut, DACK,
    input  MEMR_n, MEMW_n, IOR_n, IOW_n,
    input  EOP_out_n,
    output HLDA, EOP_in_n
  );
endinterface

// File: rtl/dma_timing_ctrl.sv
// 8237A-style transfer timing engine: HRQ/HLDA
// handshake, SI..S4 sequencing, address/count regs.
module dma_timing_ctrl #(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_CH-1:0]   chGrant,
  input  logic [NUM_CH-1:0]   dreqValid,
  input  logic [NUM_CH-1:0]   ldEn,
  input  logic [ADDR_W-1:0]   ldAddr,
  input  logic [CNT_W-1:0]    ldCount,
  input  logic [NUM_CH*6-1:0] chMode,
  input  logic                clrStatus,
  output logic [NUM_CH-1:0]   tcStatus,
  output logic [NUM_CH-1:0]   maskSet,
  dma_timing_ctrl_if.master   bus
);
  localparam int CH_W =
    (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [2:0] {
    SI, S0, S1, S2, S3, S4
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [CH_W-1:0] r_ch;
  logic [CH_W-1:0] w_gnt_idx;
  logic            w_gnt_ok;
  logic            r_hlda_lost;
  logic            r_eop;

  logic [ADDR_W-1:0] r_cur_addr  [NUM_CH];
  logic [ADDR_W-1:0] r_base_addr [NUM_CH];
  logic [CNT_W-1:0]  r_cur_cnt   [NUM_CH];
  logic [CNT_W-1:0]  r_base_cnt  [NUM_CH];
  logic [NUM_CH-1:0] r_tc;

  logic [NUM_CH-1:0] w_sel;
  logic [5:0]        w_mode;
  logic [1:0]        w_type;
  logic [1:0]        w_xfer;
  logic              w_auto;
  logic              w_dec;
  logic [ADDR_W-1:0] w_addr;
  logic [CNT_W-1:0]  w_cnt;
  logic              w_tc;
  logic              w_term;
  logic              w_rd_ph;
  logic              w_wr_ph;

  // lowest set grant bit wins if arbitration
  // ever hands over more than one
  always_comb begin
    w_gnt_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (chGrant[i]) w_gnt_idx = CH_W'(i);
    end
    w_gnt_ok = (|chGrant) && dreqValid[w_gnt_idx];
  end

  always_comb begin
    w_sel  = '0;
    w_mode = '0;
    w_addr = '0;
    w_cnt  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (r_ch == CH_W'(i)) begin
        w_sel[i] = 1'b1;
        w_mode   = chMode[i*6 +: 6];
        w_addr   = r_cur_addr[i];
        w_cnt    = r_cur_cnt[i];
      end
    end
  end

  assign w_type = w_mode[1:0];
  assign w_auto = w_mode[2];
  assign w_dec  = w_mode[3];
  assign w_xfer = w_mode[5:4];

  assign w_tc   = (r_state == S4) && (w_cnt == '0);
  assign w_term = w_tc || r_eop || !bus.EOP_in_n;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      SI: if (w_gnt_ok) w_next = S0;
      S0: if (bus.HLDA) w_next = S1;
      S1: w_next = S2;
      S2: w_next = S3;
      S3: w_next = S4;
      S4: begin
        w_next = SI;
        if (!w_term && !r_hlda_lost) begin
          unique case (w_xfer)
            2'b10:   w_next = S1;
            2'b00:   if (dreqValid[r_ch])
                       w_next = S1;
            default: w_next = SI;
          endcase
        end
      end
      default: w_next = SI;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= SI;
      r_ch        <= '0;
      r_hlda_lost <= 1'b0;
      r_eop       <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == SI) begin
        r_hlda_lost <= 1'b0;
        r_eop       <= 1'b0;
        if (w_gnt_ok) r_ch <= w_gnt_idx;
      end
      if (r_state inside {S1, S2, S3}
          && !bus.HLDA)
        r_hlda_lost <= 1'b1;
      if (r_state inside {S2, S3}
          && !bus.EOP_in_n)
        r_eop <= 1'b1;
    end
  end

  // a load strobe beats both the S4 step
  // and the autoinit reload
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_cur_addr[i]  <= '0;
        r_base_addr[i] <= '0;
        r_cur_cnt[i]   <= '0;
        r_base_cnt[i]  <= '0;
      end
      r_tc <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ldEn[i]) begin
          r_cur_addr[i]  <= ldAddr;
          r_base_addr[i] <= ldAddr;
          r_cur_cnt[i]   <= ldCount;
          r_base_cnt[i]  <= ldCount;
        end else if (r_state == S4 && w_sel[i]) begin
          if (w_term && w_auto) begin
            r_cur_addr[i] <= r_base_addr[i];
            r_cur_cnt[i]  <= r_base_cnt[i];
          end else begin
            r_cur_cnt[i] <=
              r_cur_cnt[i] - CNT_W'(1);
            r_cur_addr[i] <= w_dec
              ? r_cur_addr[i] - ADDR_W'(1)
              : r_cur_addr[i] + ADDR_W'(1);
          end
        end
      end
      r_tc <= (r_tc & ~{NUM_CH{clrStatus}})
            | (w_tc ? w_sel : '0);
    end
  end

  assign w_rd_ph = r_state inside {S2, S3};
  assign w_wr_ph = (r_state == S3);

  always_comb begin
    bus.HRQ       = (r_state != SI);
    bus.AEN       = r_state inside {S1, S2, S3, S4};
    bus.ADSTB     = (r_state == S1);
    bus.addrOut   = bus.AEN ? w_addr : '0;
    bus.DACK      = '0;
    bus.MEMR_n    = 1'b1;
    bus.MEMW_n    = 1'b1;
    bus.IOR_n     = 1'b1;
    bus.IOW_n     = 1'b1;
    bus.EOP_out_n = !w_tc;
    maskSet       = '0;
    if (r_state inside {S2, S3, S4})
      bus.DACK = w_sel;
    unique case (w_type)
      2'b10: begin
        bus.MEMR_n = !w_rd_ph;
        bus.IOW_n  = !w_wr_ph;
      end
      2'b01: begin
        bus.IOR_n  = !w_rd_ph;
        bus.MEMW_n = !w_wr_ph;
      end
      default: ;
    endcase
    if (r_state == S4 && w_term && !w_auto)
      maskSet = w_sel;
  end

  assign tcStatus = r_tc;

endmodule

// File: tb/tb_dma_timing_ctrl.sv
// Randomized bench for dma_timing_ctrl with a
// transfer-level channel model.
module tb_dma_timing_ctrl;
  localparam int N  = 4;
  localparam int AW = 16;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [N-1:0]  chGrant;
  logic [N-1:0]  dreqValid;
  logic [N-1:0]  ldEn;
  logic [AW-1:0] ldAddr;
  logic [CW-1:0] ldCount;
  logic [N*6-1:0] chMode;
  logic          clrStatus;
  logic [N-1:0]  tcStatus;
  logic [N-1:0]  maskSet;

  dma_timing_ctrl_if #(
    .NUM_CH(N), .ADDR_W(AW)
  ) bus ();

  dma_timing_ctrl #(
    .NUM_CH(N), .ADDR_W(AW), .CNT_W(CW)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .chGrant   (chGrant),
    .dreqValid (dreqValid),
    .ldEn      (ldEn),
    .ldAddr    (ldAddr),
    .ldCount   (ldCount),
    .chMode    (chMode),
    .clrStatus (clrStatus),
    .tcStatus  (tcStatus),
    .maskSet   (maskSet),
    .bus       (bus.master)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [AW-1:0] m_addr  [N];
  logic [AW-1:0] m_baddr [N];
  logic [CW-1:0] m_cnt   [N];
  logic [CW-1:0] m_bcnt  [N];
  logic [5:0]    m_mode  [N];
  logic [N-1:0]  m_tc;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h",
               tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] obs_vec();
    return {bus.HRQ, bus.AEN, bus.ADSTB,
            bus.EOP_out_n, bus.MEMR_n,
            bus.MEMW_n, bus.IOR_n, bus.IOW_n,
            bus.DACK};
  endfunction

  function automatic logic [11:0] exp_vec(
    input logic hrq, input logic aen,
    input logic adstb, input logic eop_n,
    input logic [3:0] st, input logic [N-1:0] dk);
    return {hrq, aen, adstb, eop_n, st, dk};
  endfunction

  // {MEMR_n,MEMW_n,IOR_n,IOW_n} for a phase
  function automatic logic [3:0] exp_str(
    input logic [1:0] ty, input int ph);
    logic [3:0] s;
    s = 4'hF;
    if (ty == 2'b10) begin
      if (ph == 2 || ph == 3) s[3] = 1'b0;
      if (ph == 3) s[0] = 1'b0;
    end
    if (ty == 2'b01) begin
      if (ph == 2 || ph == 3) s[1] = 1'b0;
      if (ph == 3) s[2] = 1'b0;
    end
    return s;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_addr[i]  = '0;
      m_baddr[i] = '0;
      m_cnt[i]   = '0;
      m_bcnt[i]  = '0;
    end
    m_tc = '0;
  endtask

  task automatic set_mode(input int ch,
                          input logic [5:0] md);
    chMode[ch*6 +: 6] = md;
    m_mode[ch] = md;
  endtask

  task automatic prog(input int ch,
                      input logic [AW-1:0] a,
                      input logic [CW-1:0] c);
    ldEn = '0;
    ldEn[ch] = 1'b1;
    ldAddr = a;
    ldCount = c;
    @(negedge clk);
    ldEn = '0;
    m_addr[ch] = a;
    m_baddr[ch] = a;
    m_cnt[ch] = c;
    m_bcnt[ch] = c;
  endtask

  task automatic chk_idle(input string tag);
    check({tag, "_bus"}, 32'(obs_vec()),
      32'(exp_vec(1'b0, 1'b0, 1'b0, 1'b1,
                  4'hF, '0)));
    check({tag, "_addr"},
          32'(bus.addrOut), 32'(0));
    check({tag, "_mask"}, 32'(maskSet), 32'(0));
  endtask

  task automatic chk_phase(input string tag,
                           input int ch,
                           input int ph,
                           input logic eop_n);
    logic [N-1:0] dk;
    logic [3:0]   st;
    logic [31:0]  ea;
    dk = '0;
    if (ph >= 2) dk[ch] = 1'b1;
    st = exp_str(m_mode[ch][1:0], ph);
    ea = (ph >= 1) ? 32'(m_addr[ch]) : 32'(0);
    check({tag, "_bus"}, 32'(obs_vec()),
      32'(exp_vec(1'b1, ph >= 1, ph == 1,
                  eop_n, st, dk)));
    check({tag, "_addr"}, 32'(bus.addrOut), ea);
  endtask

  // One request episode on channel ch. DREQ is
  // kept for up to `want` transfers.
  task automatic session(input int ch,
                         input int want,
                         input bit rnd,
                         input int hold,
                         input bit feop);
    logic [N-1:0]  oh;
    logic [N-1:0]  em;
    logic [AW-1:0] la;
    logic [CW-1:0] lc;
    int done, iter, eop_ph;
    bit tc, term, keep, hl_drop;
    bit ld_now, clr_now, nxt_s1, fin;
    oh = '0;
    oh[ch] = 1'b1;
    done = 0;
    iter = 0;
    fin = 0;
    la = '0;
    lc = '0;
    bus.HLDA = 1'b0;
    dreqValid = oh;
    chGrant = oh;
    @(negedge clk);
    chk_phase("s0", ch, 0, 1'b1);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk_phase("s0_hold", ch, 0, 1'b1);
    end
    bus.HLDA = 1'b1;
    @(negedge clk);
    while (!fin) begin
      iter++;
      if (iter > 40) begin
        check("xfer_budget", 32'(iter), 32'(40));
        break;
      end
      chk_phase("s1", ch, 1, 1'b1);
      hl_drop = rnd && ($urandom_range(0, 7) == 0);
      eop_ph = 0;
      if (feop && done == 0) eop_ph = 3;
      else if (rnd && $urandom_range(0, 5) == 0)
        eop_ph = int'($urandom_range(2, 3));
      @(negedge clk);
      chk_phase("s2", ch, 2, 1'b1);
      if (hl_drop) bus.HLDA = 1'b0;
      if (eop_ph == 2) bus.EOP_in_n = 1'b0;
      @(negedge clk);
      chk_phase("s3", ch, 3, 1'b1);
      if (eop_ph == 2) bus.EOP_in_n = 1'b1;
      if (eop_ph == 3) bus.EOP_in_n = 1'b0;
      @(negedge clk);
      tc = (m_cnt[ch] == '0);
      term = tc || (eop_ph != 0);
      chk_phase("s4", ch, 4, !tc);
      em = (term && !m_mode[ch][2]) ? oh : '0;
      check("mask_set", 32'(maskSet), 32'(em));
      bus.EOP_in_n = 1'b1;
      bus.HLDA = 1'b1;
      done++;
      keep = (done < want) && !term;
      if (!keep) begin
        dreqValid = '0;
        chGrant = '0;
      end
      ld_now = rnd && ($urandom_range(0, 9) == 0);
      clr_now = rnd && ($urandom_range(0, 2) == 0);
      clrStatus = clr_now;
      if (ld_now) begin
        la = AW'($urandom());
        lc = CW'($urandom_range(0, 3));
        ldEn = oh;
        ldAddr = la;
        ldCount = lc;
      end
      if (clr_now) m_tc = '0;
      if (tc) m_tc = m_tc | oh;
      if (ld_now) begin
        m_addr[ch] = la;
        m_baddr[ch] = la;
        m_cnt[ch] = lc;
        m_bcnt[ch] = lc;
      end else if (term && m_mode[ch][2]) begin
        m_addr[ch] = m_baddr[ch];
        m_cnt[ch] = m_bcnt[ch];
      end else begin
        m_cnt[ch] = m_cnt[ch] - 16'd1;
        if (m_mode[ch][3])
          m_addr[ch] = m_addr[ch] - 16'd1;
        else
          m_addr[ch] = m_addr[ch] + 16'd1;
      end
      case (m_mode[ch][5:4])
        2'b10:   nxt_s1 = 1'b1;
        2'b00:   nxt_s1 = keep;
        default: nxt_s1 = 1'b0;
      endcase
      if (term || hl_drop) nxt_s1 = 1'b0;
      @(negedge clk);
      ldEn = '0;
      clrStatus = 1'b0;
      check("tc_status", 32'(tcStatus), 32'(m_tc));
      if (!nxt_s1) begin
        chk_idle("si");
        if (keep) begin
          @(negedge clk);
          chk_phase("s0_re", ch, 0, 1'b1);
          @(negedge clk);
        end else begin
          fin = 1;
        end
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit hit");
    $fatal(1);
  end

  initial begin
    logic [5:0] md;
    int ch;
    reset_n = 1'b0;
    chGrant = '0;
    dreqValid = '0;
    ldEn = '0;
    ldAddr = '0;
    ldCount = '0;
    chMode = '0;
    clrStatus = 1'b0;
    bus.HLDA = 1'b0;
    bus.EOP_in_n = 1'b1;
    for (int i = 0; i < N; i++) m_mode[i] = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk_idle("reset");
    check("reset_tc", 32'(tcStatus), 32'(0));
    reset_n = 1'b1;
    @(negedge clk);

    // three single-mode reads, TC on the third
    set_mode(0, 6'b01_0_0_10);
    prog(0, 16'h1000, 16'd2);
    session(0, 3, 0, 0, 0);

    // block write with autoinit, address wrap
    set_mode(2, 6'b10_0_1_01);
    prog(2, 16'hFFFF, 16'd1);
    session(2, 8, 0, 1, 0);
    session(2, 8, 0, 0, 0);

    // demand: DREQ dropped after two transfers
    set_mode(1, 6'b00_0_0_10);
    prog(1, 16'h0300, 16'd5);
    session(1, 2, 0, 0, 0);
    session(1, 8, 0, 2, 0);

    // external EOP in S3 of the first transfer
    set_mode(3, 6'b01_1_0_01);
    prog(3, 16'h2000, 16'd10);
    session(3, 5, 0, 0, 1);

    // long HLDA wait in S0
    prog(0, 16'h0100, 16'd0);
    session(0, 1, 0, 20, 0);

    clrStatus = 1'b1;
    @(negedge clk);
    clrStatus = 1'b0;
    m_tc = '0;
    check("clr_status", 32'(tcStatus), 32'(m_tc));

    for (int s = 0; s < 40; s++) begin
      ch = int'($urandom_range(0, N - 1));
      md[1:0] = 2'($urandom_range(0, 2));
      md[2]   = 1'($urandom_range(0, 1));
      md[3]   = 1'($urandom_range(0, 1));
      md[5:4] = 2'($urandom_range(0, 2));
      set_mode(ch, md);
      prog(ch, AW'($urandom()),
           CW'($urandom_range(0, 4)));
      session(ch, int'($urandom_range(1, 6)),
              1, int'($urandom_range(0, 3)), 0);
    end

    // asynchronous reset in the middle of S3
    set_mode(1, 6'b01_0_0_10);
    prog(1, 16'h4444, 16'd5);
    bus.HLDA = 1'b1;
    dreqValid = 4'b0010;
    chGrant = 4'b0010;
    repeat (4) @(negedge clk);
    check("pre_rst_memr", 32'(bus.MEMR_n), 32'(0));
    #1 reset_n = 1'b0;
    #1;
    chk_idle("mid_rst");
    check("mid_rst_tc", 32'(tcStatus), 32'(0));
    dreqValid = '0;
    chGrant = '0;
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    set_mode(3, 6'b01_0_0_10);
    session(3, 1, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
